// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent run-time programmable clock dividers sharing one system clock.
// Each channel emits a 50% duty square wave plus a one-cycle tick on every toggle.
module multi_channel_clock_divider #(
    parameter int CNT_WIDTH    = 32,
    parameter int NUM_CH       = 4,
    parameter int CH_IDX_W     = 2,
    parameter int DEFAULT_HALF = 50000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sync,
    input  logic                 load_valid,
    input  logic [CH_IDX_W-1:0]  load_ch,
    input  logic [CNT_WIDTH-1:0] load_value,
    output logic [NUM_CH-1:0]    clk_out,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH-1:0]    running
);

    localparam logic [CNT_WIDTH-1:0] DEFAULT_HP = CNT_WIDTH'(DEFAULT_HALF);
    localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_WIDTH-1:0] hp_reg;
            logic [CNT_WIDTH-1:0] cnt_reg;
            logic                 out_reg;
            logic                 tick_reg;
            logic                 load_hit;
            logic                 at_term;

            // Out-of-range load_ch values match no channel and are thereby ignored.
            assign load_hit = load_valid && (load_ch == CH_IDX_W'(gi));
            assign at_term  = (cnt_reg == hp_reg - ONE);

            always_ff @(posedge clock) begin
                if (reset) begin
                    hp_reg   <= DEFAULT_HP;
                    cnt_reg  <= '0;
                    out_reg  <= 1'b0;
                    tick_reg <= 1'b0;
                end else begin
                    tick_reg <= 1'b0;
                    if (load_hit) begin
                        hp_reg <= load_value;
                    end
                    // sync clears the phase even when a load lands in the same cycle.
                    if (sync) begin
                        cnt_reg <= '0;
                        out_reg <= 1'b0;
                    end else if (load_hit) begin
                        cnt_reg <= '0;
                    end else if (enable && (hp_reg != '0)) begin
                        if (at_term) begin
                            cnt_reg  <= '0;
                            out_reg  <= ~out_reg;
                            tick_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + ONE;
                        end
                    end
                end
            end

            assign clk_out[gi] = out_reg;
            assign tick[gi]    = tick_reg;
            assign running[gi] = (hp_reg != '0);
        end
    endgenerate

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Bench for multi_channel_clock_divider: per-cycle vector table with hand-derived
// expectations, queued at drive time and compared after each rising edge.
module tb_multi_channel_clock_divider;

    logic       clock = 1'b0;
    logic       reset, enable, sync, load_valid, load_ch;
    logic [7:0] load_value;
    logic [1:0] clk_out, tick, running;

    logic       reset1, load_valid1, load_ch1;
    logic [7:0] load_value1;
    logic [0:0] clk_out1, tick1, running1;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    multi_channel_clock_divider #(
        .CNT_WIDTH(8), .NUM_CH(2), .CH_IDX_W(1), .DEFAULT_HALF(3)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .sync(sync),
        .load_valid(load_valid), .load_ch(load_ch), .load_value(load_value),
        .clk_out(clk_out), .tick(tick), .running(running)
    );

    multi_channel_clock_divider #(
        .CNT_WIDTH(8), .NUM_CH(1), .CH_IDX_W(1), .DEFAULT_HALF(3)
    ) dut1 (
        .clock(clock), .reset(reset1), .enable(1'b1), .sync(1'b0),
        .load_valid(load_valid1), .load_ch(load_ch1), .load_value(load_value1),
        .clk_out(clk_out1), .tick(tick1), .running(running1)
    );

    typedef struct {
        logic       rst, en, syn, lv, ch;
        logic [7:0] val;
        logic [1:0] co, tk, run;
    } vec_t;

    typedef struct {
        logic co, tk, run;
    } exp1_t;

    vec_t  tbl[$];
    vec_t  q0[$];
    exp1_t q1[$];

    task automatic v(input logic rst, en, syn, lv, ch, input logic [7:0] val,
                     input logic [1:0] co, tk, run);
        vec_t t;
        t.rst = rst; t.en = en; t.syn = syn; t.lv = lv; t.ch = ch; t.val = val;
        t.co = co; t.tk = tk; t.run = run;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input int row, input logic [1:0] act,
                       input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %b want %b", name, row, act, exp);
        end
    endtask

    task automatic apply(input int row, input vec_t t);
        vec_t e;
        @(negedge clock);
        reset = t.rst; enable = t.en; sync = t.syn;
        load_valid = t.lv; load_ch = t.ch; load_value = t.val;
        q0.push_back(t);
        @(posedge clock);
        #1;
        e = q0.pop_front();
        chk("clk_out", row, clk_out, e.co);
        chk("tick", row, tick, e.tk);
        chk("running", row, running, e.run);
        $display("row %0d rst=%b en=%b sync=%b lv=%b ch=%b val=%0d -> clk_out=%b tick=%b running=%b",
                 row, t.rst, t.en, t.syn, t.lv, t.ch, t.val, clk_out, tick, running);
    endtask

    task automatic step1(input int row, input logic rst, lv, input logic co, tk, run);
        exp1_t e;
        @(negedge clock);
        reset1 = rst; load_valid1 = lv; load_ch1 = 1'b1; load_value1 = 8'd0;
        e.co = co; e.tk = tk; e.run = run;
        q1.push_back(e);
        @(posedge clock);
        #1;
        e = q1.pop_front();
        chk("one_ch_clk_out", row, {1'b0, clk_out1}, {1'b0, e.co});
        chk("one_ch_tick", row, {1'b0, tick1}, {1'b0, e.tk});
        chk("one_ch_running", row, {1'b0, running1}, {1'b0, e.run});
        $display("one_ch row %0d rst=%b lv=%b ch=1 -> clk_out=%b tick=%b running=%b",
                 row, rst, lv, clk_out1, tick1, running1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sync = 1'b0;
        load_valid = 1'b0; load_ch = 1'b0; load_value = 8'd0;
        reset1 = 1'b1; load_valid1 = 1'b0; load_ch1 = 1'b0; load_value1 = 8'd0;

        // reset, then both channels at hp=3
        v(1,1,0,0,0,0, 2'b00,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b00,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b00,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b11,2'b11,2'b11);
        v(0,1,0,0,0,0, 2'b11,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b11,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b00,2'b11,2'b11);
        v(0,1,0,0,0,0, 2'b00,2'b00,2'b11);
        // ch1 <= 5 mid-count; ch0 keeps its phase
        v(0,1,0,1,1,5, 2'b00,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b01,2'b01,2'b11);
        v(0,1,0,0,0,0, 2'b01,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b01,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b00,2'b01,2'b11);
        v(0,1,0,0,0,0, 2'b10,2'b10,2'b11);
        v(0,1,0,0,0,0, 2'b10,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b11,2'b01,2'b11);
        // ch0 <= 0 freezes it high, then ch0 <= 1 toggles every cycle
        v(0,1,0,1,0,0, 2'b11,2'b00,2'b10);
        v(0,1,0,0,0,0, 2'b11,2'b00,2'b10);
        v(0,1,0,0,0,0, 2'b01,2'b10,2'b10);
        v(0,1,0,0,0,0, 2'b01,2'b00,2'b10);
        v(0,1,0,1,0,1, 2'b01,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b00,2'b01,2'b11);
        v(0,1,0,0,0,0, 2'b01,2'b01,2'b11);
        v(0,1,0,0,0,0, 2'b10,2'b11,2'b11);
        v(0,1,0,0,0,0, 2'b11,2'b01,2'b11);
        // ch0 <= 3, advance to cnt=1, then disable for 7 cycles
        v(0,1,0,1,0,3, 2'b11,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b11,2'b00,2'b11);
        for (int i = 0; i < 7; i++) v(0,0,0,0,0,0, 2'b11,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b11,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b00,2'b11,2'b11);
        v(0,1,0,0,0,0, 2'b00,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b00,2'b00,2'b11);
        // load on ch0 terminal count: no toggle, no tick
        v(0,1,0,1,0,3, 2'b00,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b00,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b10,2'b10,2'b11);
        v(0,1,0,0,0,0, 2'b11,2'b01,2'b11);
        // ch1 <= 3 out of phase with ch0, then sync realigns them
        v(0,1,0,1,1,3, 2'b11,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b11,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b10,2'b01,2'b11);
        v(0,1,1,0,0,0, 2'b00,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b00,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b00,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b11,2'b11,2'b11);
        v(0,1,0,0,0,0, 2'b11,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b11,2'b00,2'b11);
        // reset mid-count restores hp=3
        v(1,1,0,0,0,0, 2'b00,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b00,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b00,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b11,2'b11,2'b11);
        // sync together with load ch1 <= 2
        v(0,1,1,1,1,2, 2'b00,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b00,2'b00,2'b11);
        v(0,1,0,0,0,0, 2'b10,2'b10,2'b11);
        v(0,1,0,0,0,0, 2'b11,2'b01,2'b11);
        v(0,1,0,0,0,0, 2'b01,2'b10,2'b11);

        foreach (tbl[i]) apply(i, tbl[i]);

        // single-channel build: load_ch=1 is out of range and must be ignored
        step1(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step1(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step1(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step1(3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step1(4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
